// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: GPU write handshake plus framebuffer RAM port
//   wr_valid/wr_ready/wr_addr/wr_data : GPU pixel-write request channel
//   mem_en/mem_we/mem_addr/mem_wdata  : RAM access strobe, write enable, address, write data
//   mem_rdata                         : RAM read data, valid the cycle after a read
//   slave modport is the arbiter's view, master the GPU/RAM side
interface vga_fb_arbiter_if #(
   parameter int AW = 19,
   parameter int DW = 16
);
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   modport slave (
      input  wr_valid, wr_addr, wr_data, mem_rdata,
      output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output wr_valid, wr_addr, wr_data, mem_rdata,
      input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one framebuffer RAM between VGA scanout (priority) and a FIFO-buffered GPU write port
//   clk, rst                  : pixel clock, asynchronous active-low reset
//   t_hsync/t_vsync/t_valid   : video timer strobes
//   bus                       : GPU write channel and RAM port (slave modport)
//   pix_valid/pix_data        : scanout pixel, aligned with RAM read data
//   hsync_o/vsync_o           : timer syncs delayed one cycle to match pix_data
//   frame_start               : one-cycle pulse on a t_vsync rising edge
//   wbuf_level                : write FIFO occupancy
module vga_fb_arbiter #(
   parameter  int HACTIVE    = 800,
   parameter  int VACTIVE    = 600,
   parameter  int AW         = 19,
   parameter  int DW         = 16,
   parameter  int WBUF_DEPTH = 4,
   localparam int PW         = $clog2(WBUF_DEPTH),
   localparam int LW         = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          t_hsync,
   input  logic          t_vsync,
   input  logic          t_valid,
   vga_fb_arbiter_if.slave bus,
   output logic          pix_valid,
   output logic [DW-1:0] pix_data,
   output logic          hsync_o,
   output logic          vsync_o,
   output logic          frame_start,
   output logic [LW-1:0] wbuf_level
);
   localparam int NPIX = HACTIVE * VACTIVE;

   logic [AW+DW-1:0] wbuf_q [WBUF_DEPTH];
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [LW-1:0]    level_q, level_d;
   logic [AW-1:0]    rd_addr_q, rd_addr_d;
   logic             pix_valid_q, pix_valid_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             push, pop, rd;
   logic [AW-1:0]    head_addr;
   logic [DW-1:0]    head_data;

   assign {head_addr, head_data} = wbuf_q[head_q];

   always_comb begin
      // readiness looks only at registered occupancy, so a same-cycle pop never frees a slot
      bus.wr_ready  = rst && (level_q != LW'(WBUF_DEPTH));
      push          = bus.wr_valid && bus.wr_ready;
      rd            = rst && t_valid;
      pop           = rst && !t_valid && (level_q != '0);
      frame_start   = rst && t_vsync && !vsync_q;
      bus.mem_en    = rd || pop;
      bus.mem_we    = pop;
      bus.mem_addr  = rd ? rd_addr_q : pop ? head_addr : '0;
      bus.mem_wdata = pop ? head_data : '0;
      head_d        = pop ? head_q + 1'b1 : head_q;
      tail_d        = push ? tail_q + 1'b1 : tail_q;
      level_d       = level_q + LW'(push) - LW'(pop);
      // a vsync edge re-aligns scanout and wins over the increment
      rd_addr_d     = frame_start ? '0 :
                      !rd ? rd_addr_q :
                      (rd_addr_q == AW'(NPIX - 1)) ? '0 : rd_addr_q + 1'b1;
      pix_valid_d   = t_valid;
      hsync_d       = t_hsync;
      vsync_d       = t_vsync;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         level_q     <= '0;
         rd_addr_q   <= '0;
         pix_valid_q <= 1'b0;
         hsync_q     <= 1'b0;
         vsync_q     <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         level_q     <= level_d;
         rd_addr_q   <= rd_addr_d;
         pix_valid_q <= pix_valid_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) wbuf_q[tail_q] <= {bus.wr_addr, bus.wr_data};
   end

   assign pix_valid  = pix_valid_q;
   assign pix_data   = pix_valid_q ? bus.mem_rdata : '0;
   assign hsync_o    = hsync_q;
   assign vsync_o    = vsync_q;
   assign wbuf_level = level_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed checks of vga_fb_arbiter with a behavioural 1-cycle RAM
module tb_vga_fb_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        t_hsync, t_vsync, t_valid;
   logic        pix_valid, hsync_o, vsync_o, frame_start;
   logic [15:0] pix_data;
   logic [2:0]  wbuf_level;
   logic        s_vsync, s_valid;
   logic        s_pix_valid, s_hsync_o, s_vsync_o, s_frame_start;
   logic [15:0] s_pix_data;
   logic [1:0]  s_level;
   logic [15:0] rdata_q;
   logic [15:0] ram_w [int];
   logic [15:0] exp_w [int];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   vga_fb_arbiter_if #(.AW(19), .DW(16)) bus ();
   vga_fb_arbiter_if #(.AW(4),  .DW(16)) sbus ();

   vga_fb_arbiter u_dut (
      .clk(clk), .rst(rst), .t_hsync(t_hsync), .t_vsync(t_vsync), .t_valid(t_valid),
      .bus(bus), .pix_valid(pix_valid), .pix_data(pix_data), .hsync_o(hsync_o),
      .vsync_o(vsync_o), .frame_start(frame_start), .wbuf_level(wbuf_level)
   );

   vga_fb_arbiter #(.HACTIVE(4), .VACTIVE(3), .AW(4), .DW(16), .WBUF_DEPTH(2)) u_small (
      .clk(clk), .rst(rst), .t_hsync(1'b0), .t_vsync(s_vsync), .t_valid(s_valid),
      .bus(sbus), .pix_valid(s_pix_valid), .pix_data(s_pix_data), .hsync_o(s_hsync_o),
      .vsync_o(s_vsync_o), .frame_start(s_frame_start), .wbuf_level(s_level)
   );

   assign bus.mem_rdata  = rdata_q;
   assign sbus.mem_rdata = 16'h0;
   assign sbus.wr_valid  = 1'b0;
   assign sbus.wr_addr   = 4'h0;
   assign sbus.wr_data   = 16'h0;

   // RAM model: unwritten locations read back their own address
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) ram_w[int'(bus.mem_addr)] = bus.mem_wdata;
      if (bus.mem_en && !bus.mem_we)
         rdata_q <= ram_w.exists(int'(bus.mem_addr)) ? ram_w[int'(bus.mem_addr)] : bus.mem_addr[15:0];
   end

   // expected framebuffer contents, built from accepted GPU writes
   always @(posedge clk) begin
      if (bus.wr_valid && bus.wr_ready) exp_w[int'(bus.wr_addr)] = bus.wr_data;
   end

   function automatic logic [15:0] exp_pix(input int a);
      return exp_w.exists(a) ? exp_w[a] : 16'(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int acc;
      logic ph;
      rst = 1'b0; t_hsync = 1'b0; t_vsync = 1'b0; t_valid = 1'b0;
      s_vsync = 1'b0; s_valid = 1'b0;
      bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      #2;
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_data", pix_data, 0);
      chk("rst_level", wbuf_level, 0);
      t_valid = 1'b1; t_vsync = 1'b1;
      #1;
      chk("rst_no_mem_en", bus.mem_en, 0);
      chk("rst_no_frame_start", frame_start, 0);
      t_valid = 1'b0; t_vsync = 1'b0;
      @(posedge clk); nxt();
      rst = 1'b1;
      #1;
      chk("idle_wr_ready", bus.wr_ready, 1);
      chk("idle_mem_en", bus.mem_en, 0);
      chk("idle_level", wbuf_level, 0);
      chk("idle_syncs", {hsync_o, vsync_o, frame_start, pix_valid}, 0);

      // three writes while idle: each drains the cycle after its push
      nxt(); bus.wr_valid = 1'b1; bus.wr_addr = 5; bus.wr_data = 16'hA1; #1;
      chk("w0_ready", bus.wr_ready, 1);
      chk("w0_no_bypass", bus.mem_en, 0);
      nxt(); bus.wr_addr = 6; bus.wr_data = 16'hA2; #1;
      chk("w1_we", bus.mem_we, 1);
      chk("w1_addr", bus.mem_addr, 5);
      chk("w1_data", bus.mem_wdata, 16'hA1);
      chk("w1_level", wbuf_level, 1);
      nxt(); bus.wr_addr = 7; bus.wr_data = 16'hA3; #1;
      chk("w2_addr", bus.mem_addr, 6);
      chk("w2_data", bus.mem_wdata, 16'hA2);
      chk("w2_level", wbuf_level, 1);
      nxt(); bus.wr_valid = 1'b0; #1;
      chk("w3_we", bus.mem_we, 1);
      chk("w3_addr", bus.mem_addr, 7);
      chk("w3_data", bus.mem_wdata, 16'hA3);
      nxt(); #1;
      chk("w4_idle", bus.mem_en, 0);
      chk("w4_level", wbuf_level, 0);

      // active video blocks draining; FIFO fills and back-pressures
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         nxt();
         t_valid = 1'b1;
         bus.wr_valid = 1'b1; bus.wr_addr = 19'(100 + acc); bus.wr_data = 16'(16'h0B00 + acc);
         #1;
         chk("act_ready", bus.wr_ready, (i < 4) ? 1 : 0);
         chk("act_level", wbuf_level, (i < 4) ? i : 4);
         chk("act_read", {bus.mem_en, bus.mem_we}, 2'b10);
         if (bus.wr_ready) acc++;
      end
      chk("act_accepted", acc, 4);
      // blanking: six writes drain in order; the full cycle rejects a push even while popping
      for (int j = 0; j < 6; j++) begin
         nxt();
         t_valid = 1'b0;
         bus.wr_valid = (acc < 6); bus.wr_addr = 19'(100 + acc); bus.wr_data = 16'(16'h0B00 + acc);
         #1;
         chk("drain_ready", bus.wr_ready, (j == 0) ? 0 : 1);
         chk("drain_level", wbuf_level, (j == 0) ? 4 : (j < 4) ? 3 : 6 - j);
         chk("drain_we", bus.mem_we, 1);
         chk("drain_addr", bus.mem_addr, 100 + j);
         chk("drain_data", bus.mem_wdata, 16'h0B00 + j);
         if (bus.wr_valid && bus.wr_ready) acc++;
      end
      nxt(); bus.wr_valid = 1'b0; #1;
      chk("drain_done_level", wbuf_level, 0);
      chk("drain_done_en", bus.mem_en, 0);
      chk("drain_all_accepted", acc, 6);

      // scanout of one line after a vsync pulse
      nxt(); t_vsync = 1'b1; #1;
      chk("fs_pulse", frame_start, 1);
      nxt(); t_vsync = 1'b0; #1;
      chk("fs_once", frame_start, 0);
      chk("vsync_lag", vsync_o, 1);
      ph = 1'b0;
      for (int i = 0; i < 800; i++) begin
         nxt();
         t_valid = 1'b1; t_hsync = (i % 7 == 0);
         #1;
         chk("scan_addr", bus.mem_addr, i);
         chk("scan_pix_valid", pix_valid, (i > 0) ? 1 : 0);
         chk("scan_pix", pix_data, (i > 0) ? exp_pix(i - 1) : 0);
         chk("hsync_lag", hsync_o, ph);
         ph = t_hsync;
      end
      nxt(); t_valid = 1'b0; t_hsync = 1'b0; #1;
      chk("scan_last_pix", pix_data, exp_pix(799));
      chk("scan_last_hsync", hsync_o, ph);
      nxt(); #1;
      chk("scan_end_valid", pix_valid, 0);
      chk("scan_end_pix", pix_data, 0);

      // advance to rd_addr 1234, then a vsync edge restarts at 0
      for (int i = 0; i < 434; i++) begin
         nxt(); t_valid = 1'b1; #1;
         chk("adv_addr", bus.mem_addr, 800 + i);
      end
      nxt(); t_vsync = 1'b1; #1;
      chk("resync_addr", bus.mem_addr, 1234);
      chk("resync_fs", frame_start, 1);
      nxt(); #1;
      chk("resync_fs_once", frame_start, 0);
      chk("resync_first", bus.mem_addr, 0);
      chk("resync_pix", pix_data, 16'(1234));
      nxt(); t_vsync = 1'b0; #1;
      chk("resync_second", bus.mem_addr, 1);
      nxt(); t_valid = 1'b0;

      // address wrap on a 4x3 instance
      nxt(); s_vsync = 1'b1; #1;
      chk("small_fs", s_frame_start, 1);
      nxt(); s_vsync = 1'b0;
      for (int i = 0; i < 13; i++) begin
         nxt(); s_valid = 1'b1; #1;
         chk("small_wrap_addr", sbus.mem_addr, i % 12);
      end
      nxt(); s_valid = 1'b0;

      // reset mid-frame discards buffered writes
      nxt(); t_vsync = 1'b1;
      nxt(); t_vsync = 1'b0; t_valid = 1'b1;
      bus.wr_valid = 1'b1; bus.wr_addr = 1500; bus.wr_data = 16'hDEAD;
      nxt(); bus.wr_addr = 1501;
      nxt(); bus.wr_valid = 1'b0; #1;
      chk("mid_level", wbuf_level, 2);
      chk("mid_pix_valid", pix_valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_level", wbuf_level, 0);
      chk("mid_rst_pix_valid", pix_valid, 0);
      chk("mid_rst_pix_data", pix_data, 0);
      chk("mid_rst_mem_en", bus.mem_en, 0);
      chk("mid_rst_ready", bus.wr_ready, 0);
      nxt(); #1;
      chk("mid_rst_hold_en", bus.mem_en, 0);
      nxt();
      rst = 1'b1; t_valid = 1'b0;
      #1;
      chk("post_rst_no_write", bus.mem_en, 0);
      chk("post_rst_level", wbuf_level, 0);
      nxt(); t_vsync = 1'b1; t_valid = 1'b1; #1;
      chk("post_rst_fs", frame_start, 1);
      chk("post_rst_addr", bus.mem_addr, 0);
      nxt(); t_vsync = 1'b0; t_valid = 1'b0;
      nxt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
